popcount_window: RTL and testbench

Parametrised, registered successor to the team's 4-input combinational ones-counter. It counts the set bits of a WIDTH-bit sample and emits the count both in binary and as a one-hot "exactly k ones" vector, generalising the fixed 4-input count-of-0..4 decode. It adds a window mode that sums counts over WINDOW samples. Valid/ready handshakes on both sides let it sit between a sampling front end and downstream threshold logic.

---
 rtl/popcount_pkg.sv | 23 ++
 rtl/popcount_tree.sv | 36 +++
 rtl/popcount_window.sv | 145 ++++++++++++++
 tb/tb_popcount_window.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/popcount_pkg.sv
// Shared types and width helpers for the windowed popcount block.
// Imported by popcount_tree and popcount_window.
package popcount_pkg;

  typedef enum logic {
    MODE_SAMPLE = 1'b0,
    MODE_WINDOW = 1'b1
  } mode_e;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_HOLD    = 1'b1
  } state_e;

  function automatic int cw_of(input int width);
    return $clog2(width + 1);
  endfunction

  function automatic int sw_of(input int width, input int window);
    return $clog2(width * window + 1);
  endfunction

endpackage

// File: rtl/popcount_tree.sv
// Combinational ones-counter built as a balanced binary adder tree.
// Leaves past WIDTH are padded with zero up to the next power of two.
module popcount_tree
  import popcount_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CW = cw_of(WIDTH)
) (
  input  logic [WIDTH-1:0] data,
  output logic [CW-1:0]    count
);

  localparam int LV = $clog2(WIDTH);
  localparam int P  = 1 << LV;

  for (genvar l = 0; l <= LV; l++) begin : g_lvl
    localparam int N = P >> l;
    logic [CW-1:0] s [N];
    if (l == 0) begin : g_leaf
      for (genvar i = 0; i < N; i++) begin : g_i
        if (i < WIDTH) begin : g_bit
          assign s[i] = CW'(data[i]);
        end else begin : g_pad
          assign s[i] = '0;
        end
      end
    end else begin : g_sum
      for (genvar i = 0; i < N; i++) begin : g_i
        assign s[i] = g_lvl[l-1].s[2*i] + g_lvl[l-1].s[2*i+1];
      end
    end
  end

  assign count = g_lvl[LV].s[0];

endmodule

// File: rtl/popcount_window.sv
// Registered popcount with binary + one-hot outputs and a windowed sum
// mode, valid/ready on both sides.
module popcount_window
  import popcount_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int WINDOW = 16,
  localparam int CW = cw_of(WIDTH),
  localparam int SW = sw_of(WIDTH, WINDOW)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_count,
  output logic [WIDTH:0]   out_onehot,
  output logic [SW-1:0]    out_sum,
  output logic             out_last
);

  localparam int NW = $clog2(WINDOW);
  localparam logic [NW-1:0] LAST = NW'(WINDOW - 1);

  state_e          state_q, state_d;
  mode_e           mode_q, mode_d, mode_eff;
  logic [NW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   last_cnt_q, last_cnt_d;
  logic [CW-1:0]   out_count_q, out_count_d;
  logic [WIDTH:0]  out_onehot_q, out_onehot_d;
  logic [SW-1:0]   out_sum_q, out_sum_d;
  logic            out_last_q, out_last_d;

  logic [CW-1:0]   cnt_s;
  logic [SW-1:0]   sum_in;
  logic            in_acc, drain_ok, emit;
  logic            samp_beat, win_end, win_add, flush_only;

  popcount_tree #(.WIDTH(WIDTH)) u_tree (
    .data  (in_data),
    .count (cnt_s)
  );

  assign out_valid = (state_q == ST_HOLD);
  assign drain_ok  = !out_valid || out_ready;
  assign in_ready  = rst || drain_ok;
  assign in_acc    = in_valid && in_ready;

  assign out_count  = out_count_q;
  assign out_onehot = out_onehot_q;
  assign out_sum    = out_sum_q;
  assign out_last   = out_last_q;

  always_comb begin
    mode_eff = mode_q;
    if (in_acc && cnt_q == '0) mode_eff = mode_e'(mode);
    sum_in = acc_q + SW'(cnt_s);

    samp_beat  = in_acc && mode_eff == MODE_SAMPLE;
    win_end    = in_acc && mode_eff == MODE_WINDOW
                 && (cnt_q == LAST || flush);
    win_add    = in_acc && mode_eff == MODE_WINDOW
                 && !(cnt_q == LAST || flush);
    flush_only = !in_acc && flush && drain_ok && cnt_q != '0;

    state_d      = state_q;
    mode_d       = mode_eff;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    last_cnt_d   = last_cnt_q;
    out_count_d  = out_count_q;
    out_onehot_d = out_onehot_q;
    out_sum_d    = out_sum_q;
    out_last_d   = out_last_q;
    emit         = 1'b0;

    if (in_acc) last_cnt_d = cnt_s;

    unique case (1'b1)
      samp_beat: begin
        emit         = 1'b1;
        out_count_d  = cnt_s;
        out_onehot_d = (WIDTH+1)'(1) << cnt_s;
        out_sum_d    = SW'(cnt_s);
        out_last_d   = 1'b0;
      end
      win_end: begin
        emit         = 1'b1;
        out_count_d  = cnt_s;
        out_onehot_d = (WIDTH+1)'(1) << cnt_s;
        out_sum_d    = sum_in;
        out_last_d   = 1'b1;
        acc_d        = '0;
        cnt_d        = '0;
      end
      win_add: begin
        acc_d = sum_in;
        cnt_d = cnt_q + NW'(1);
      end
      flush_only: begin
        emit         = 1'b1;
        out_count_d  = last_cnt_q;
        out_onehot_d = (WIDTH+1)'(1) << last_cnt_q;
        out_sum_d    = acc_q;
        out_last_d   = 1'b1;
        acc_d        = '0;
        cnt_d        = '0;
      end
      default: ;
    endcase

    if (emit) state_d = ST_HOLD;
    else if (out_valid && out_ready) state_d = ST_COLLECT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_COLLECT;
      mode_q       <= MODE_SAMPLE;
      cnt_q        <= '0;
      acc_q        <= '0;
      last_cnt_q   <= '0;
      out_count_q  <= '0;
      out_onehot_q <= '0;
      out_sum_q    <= '0;
      out_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      last_cnt_q   <= last_cnt_d;
      out_count_q  <= out_count_d;
      out_onehot_q <= out_onehot_d;
      out_sum_q    <= out_sum_d;
      out_last_q   <= out_last_d;
    end
  end

endmodule

// File: tb/tb_popcount_window.sv
// Bench for popcount_window: two instances (WINDOW=4 and 16) on shared
// stimulus, directed scenarios then random traffic vs a reference model.
module tb_popcount_window;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mode = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] in_data = 8'h00;

  always #5 clk = ~clk;

  logic       ir4, ov4, ol4, ir16, ov16, ol16;
  logic [3:0] oc4, oc16;
  logic [8:0] oh4, oh16;
  logic [5:0] os4;
  logic [7:0] os16;

  popcount_window #(.WIDTH(8), .WINDOW(4)) u_dut4 (
    .clk(clk), .rst(rst), .mode(mode), .flush(flush),
    .in_valid(in_valid), .in_ready(ir4), .in_data(in_data),
    .out_valid(ov4), .out_ready(out_ready), .out_count(oc4),
    .out_onehot(oh4), .out_sum(os4), .out_last(ol4)
  );

  popcount_window #(.WIDTH(8), .WINDOW(16)) u_dut16 (
    .clk(clk), .rst(rst), .mode(mode), .flush(flush),
    .in_valid(in_valid), .in_ready(ir16), .in_data(in_data),
    .out_valid(ov16), .out_ready(out_ready), .out_count(oc16),
    .out_onehot(oh16), .out_sum(os16), .out_last(ol16)
  );

  logic [31:0] o_ir [2], o_ov [2], o_oc [2];
  logic [31:0] o_oh [2], o_os [2], o_ol [2];
  assign o_ir[0] = 32'(ir4);  assign o_ir[1] = 32'(ir16);
  assign o_ov[0] = 32'(ov4);  assign o_ov[1] = 32'(ov16);
  assign o_oc[0] = 32'(oc4);  assign o_oc[1] = 32'(oc16);
  assign o_oh[0] = 32'(oh4);  assign o_oh[1] = 32'(oh16);
  assign o_os[0] = 32'(os4);  assign o_os[1] = 32'(os16);
  assign o_ol[0] = 32'(ol4);  assign o_ol[1] = 32'(ol16);

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model: pending beat plus running window tally per instance
  int win [2] = '{4, 16};
  bit known = 1'b0;
  bit mv [2];
  int mc [2], msum [2], mlast [2], mmode [2], mn [2], macc [2], mlc [2];

  task automatic check_model();
    for (int d = 0; d < 2; d++) begin
      if (rst || known)
        check($sformatf("in_ready%0d", d), o_ir[d],
              32'(rst || !mv[d] || out_ready));
      if (known) begin
        check($sformatf("out_valid%0d", d), o_ov[d], 32'(mv[d]));
        if (mv[d]) begin
          check($sformatf("out_count%0d", d), o_oc[d], mc[d]);
          check($sformatf("out_onehot%0d", d), o_oh[d], 32'(1) << mc[d]);
          check($sformatf("out_sum%0d", d), o_os[d], msum[d]);
          check($sformatf("out_last%0d", d), o_ol[d], mlast[d]);
        end
      end
    end
  endtask

  task automatic drive(input bit v, input logic [7:0] dat, input bit m,
                       input bit f, input bit r, input bit rs);
    @(negedge clk);
    in_valid = v; in_data = dat; mode = m;
    flush = f; out_ready = r; rst = rs;
    #1;
    check_model();
  endtask

  task automatic tick();
    bit rdy, acc, emit;
    int c, ec, es, el;
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        mv[d] = 0; mc[d] = 0; msum[d] = 0; mlast[d] = 0;
        mmode[d] = 0; mn[d] = 0; macc[d] = 0; mlc[d] = 0;
        continue;
      end
      rdy = !mv[d] || out_ready;
      acc = in_valid && rdy;
      emit = 0; ec = 0; es = 0; el = 0;
      if (acc) begin
        c = $countones(in_data);
        mlc[d] = c;
        if (mn[d] == 0) mmode[d] = int'(mode);
        if (mmode[d] == 0) begin
          emit = 1; ec = c; es = c; el = 0;
        end else begin
          macc[d] += c;
          mn[d]++;
          if (mn[d] == win[d] || flush) begin
            emit = 1; ec = c; es = macc[d]; el = 1;
            macc[d] = 0; mn[d] = 0;
          end
        end
      end else if (flush && rdy && mn[d] > 0) begin
        emit = 1; ec = mlc[d]; es = macc[d]; el = 1;
        macc[d] = 0; mn[d] = 0;
      end
      if (emit) begin
        mv[d] = 1; mc[d] = ec; msum[d] = es; mlast[d] = el;
      end else if (mv[d] && out_ready) begin
        mv[d] = 0;
      end
    end
    if (rst) known = 1;
  endtask

  task automatic idle();
    drive(0, 8'h00, 0, 0, 1, 0);
  endtask

  initial begin
    // reset, then mid-window reset
    drive(0, 8'h00, 0, 0, 1, 1); tick();
    drive(0, 8'h00, 0, 0, 1, 1); tick();
    drive(1, 8'hFF, 1, 0, 1, 0); tick();
    drive(1, 8'hFF, 1, 0, 1, 0); tick();
    drive(1, 8'hFF, 1, 0, 1, 1); tick();
    drive(1, 8'hFF, 1, 0, 1, 1);
    check("rst_valid", o_ov[0], 0);
    check("rst_ready", o_ir[0], 1);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1, 8'h01, 1, 0, 1, 0); tick();
    end
    idle();
    check("rst_sum", o_os[0], 4);
    check("rst_beat", o_ov[0], 1);
    tick();
    drive(0, 8'h00, 0, 1, 1, 0); tick();
    idle();
    check("flush16_sum", o_os[1], 4);
    check("flush16_none4", o_ov[0], 0);
    tick();

    // SAMPLE mode
    drive(1, 8'hFF, 0, 0, 1, 0); tick();
    drive(1, 8'h00, 0, 0, 1, 0);
    check("ff_count", o_oc[0], 8);
    check("ff_onehot", o_oh[0], 32'h100);
    tick();
    drive(1, 8'hA5, 0, 0, 1, 0);
    check("00_count", o_oc[0], 0);
    check("00_onehot", o_oh[0], 32'h001);
    tick();
    idle();
    check("a5_count", o_oc[0], 4);
    check("a5_onehot", o_oh[0], 32'h010);
    check("a5_sum", o_os[0], 4);
    check("a5_last", o_ol[0], 0);
    tick();

    // WINDOW=4
    drive(1, 8'h0F, 1, 0, 1, 0); tick();
    drive(1, 8'h03, 1, 0, 1, 0); tick();
    drive(1, 8'hFF, 1, 0, 1, 0); tick();
    drive(1, 8'h01, 1, 0, 1, 0); tick();
    idle();
    check("win_valid", o_ov[0], 1);
    check("win_sum", o_os[0], 15);
    check("win_count", o_oc[0], 1);
    check("win_last", o_ol[0], 1);
    tick();
    idle();
    check("win_once", o_ov[0], 0);
    tick();
    drive(0, 8'h00, 0, 1, 1, 0); tick();
    idle(); tick();

    // backpressure
    drive(1, 8'h3C, 0, 0, 0, 0); tick();
    for (int i = 0; i < 5; i++) begin
      drive(1, 8'(i * 37 + 1), 0, 0, 0, 0);
      check("bp_ready", o_ir[0], 0);
      check("bp_count", o_oc[0], 4);
      tick();
    end
    drive(1, 8'h07, 0, 0, 1, 0);
    check("bp_release", o_ir[0], 1);
    tick();
    idle();
    check("bp_next", o_oc[0], 3);
    check("bp_nvalid", o_ov[0], 1);
    tick();

    // flush
    drive(1, 8'hAA, 1, 0, 1, 0); tick();
    drive(1, 8'h55, 1, 0, 1, 0); tick();
    drive(0, 8'h00, 1, 1, 1, 0); tick();
    idle();
    check("fl_sum", o_os[0], 8);
    check("fl_last", o_ol[0], 1);
    tick();
    drive(0, 8'h00, 1, 1, 1, 0); tick();
    idle();
    check("fl_empty", o_ov[0], 0);
    tick();
    drive(1, 8'h03, 1, 0, 1, 0); tick();
    drive(1, 8'h01, 1, 1, 1, 0); tick();
    idle();
    check("fl_coinc4", o_os[0], 3);
    check("fl_coinc16", o_os[1], 3);
    tick();

    // full 16-sample window, mode toggling mid-window
    for (int i = 0; i < 16; i++) begin
      drive(1, 8'hFF, (i % 2) == 0, 0, 1, 0); tick();
    end
    idle();
    check("w16_valid", o_ov[1], 1);
    check("w16_sum", o_os[1], 128);
    check("w16_last", o_ol[1], 1);
    tick();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(3) != 0, 8'($urandom), 1'($urandom),
            $urandom_range(7) == 0, $urandom_range(3) != 0,
            $urandom_range(99) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
